// File: rtl/adder_pipe_act.sv
// Unsigned N-bit adder with a segmented carry pipeline, valid/ready
// handshake, wrap/saturate output and an input toggle counter.
module adder_pipe_act #(
   parameter int N      = 32,
   parameter int STAGES = 4,
   parameter int SAT    = 0,
   parameter int CW     = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_a,
   input  logic [N-1:0]  in_b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_sum,
   output logic          out_cout,
   input  logic          act_clr,
   output logic [CW-1:0] act_cnt
);

   localparam int SEG = N / STAGES;
   localparam int TW  = $clog2(2 * N + 1);

   if (N % STAGES != 0) begin : g_bad_n
      $error("adder_pipe_act: N must be a multiple of STAGES");
   end
   if (STAGES < 1 || STAGES > 8) begin : g_bad_st
      $error("adder_pipe_act: STAGES must be 1..8");
   end

   logic          adv;
   logic          xfer;
   logic          vld_q;
   logic          cout_q;
   logic [N-1:0]  sum_q;
   logic [N-1:0]  prev_a;
   logic [N-1:0]  prev_b;
   logic [CW-1:0] act_q;
   logic [TW-1:0] tog;
   logic [CW:0]   acc;

   assign adv      = !vld_q || out_ready;
   assign in_ready = adv;
   assign xfer     = in_valid && adv;

   // Stage k sees full operands plus the partial sum of segments below k.
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int LO = k * SEG;
      localparam logic [N-1:0] M = ({N{1'b1}} >> (N - SEG)) << LO;
      localparam logic [N:0]   CB = (N + 1)'(1) << (LO + SEG);

      logic [N-1:0] ia;
      logic [N-1:0] ib;
      logic [N-1:0] is;
      logic         ic;
      logic         iv;
      logic [N:0]   t;
      logic [N-1:0] ns;
      logic         nc;

      assign t  = {1'b0, ia & M} + {1'b0, ib & M}
                + ((N + 1)'(ic) << LO);
      assign ns = is | (t[N-1:0] & M);
      assign nc = |(t & CB);

      if (k == 0) begin : g_in
         assign ia = in_a;
         assign ib = in_b;
         assign is = '0;
         assign ic = 1'b0;
         assign iv = in_valid;
      end else begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ia <= '0;
               ib <= '0;
               is <= '0;
               ic <= 1'b0;
               iv <= 1'b0;
            end else if (adv) begin
               ia <= g_st[k-1].ia;
               ib <= g_st[k-1].ib;
               is <= g_st[k-1].ns;
               ic <= g_st[k-1].nc;
               iv <= g_st[k-1].iv;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else if (adv) begin
         vld_q  <= g_st[STAGES-1].iv;
         cout_q <= g_st[STAGES-1].nc;
         sum_q  <= ((SAT != 0) && g_st[STAGES-1].nc) ?
                   {N{1'b1}} : g_st[STAGES-1].ns;
      end
   end

   assign out_valid = vld_q;
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;

   // A clear coinciding with a transfer restarts from this transfer's toggles.
   always_comb begin
      tog = TW'($countones(in_a ^ prev_a))
          + TW'($countones(in_b ^ prev_b));
      acc = {1'b0, act_clr ? {CW{1'b0}} : act_q} + (CW + 1)'(tog);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_a <= '0;
         prev_b <= '0;
         act_q  <= '0;
      end else if (xfer) begin
         prev_a <= in_a;
         prev_b <= in_b;
         act_q  <= acc[CW] ? {CW{1'b1}} : acc[CW-1:0];
      end else if (act_clr) begin
         act_q  <= '0;
      end
   end

   assign act_cnt = act_q;

endmodule
